// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S receiver slice.
//   state_t        - deframer state (IDLE, SHIFT, DONE, WAIT)
//   I2S_DELAY_BITS - Philips I2S puts the MSB one BCLK after the LRCLK edge
//   i2s_cnt_w()    - bit-counter width able to hold 0..data_width
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int I2S_DELAY_BITS = 1;

  function automatic int i2s_cnt_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/i2s_if.sv
// i2s_if: codec-side serial pins plus the parallel sample outputs.
//   bclk, lrclk, sdata      - serial I2S from the codec (asynchronous to clk)
//   leftOut, rightOut       - last complete signed sample pair
//   sampleValid             - one-clk strobe when the pair updates
//   frameError              - one-clk strobe when a partial word is dropped
// master: the codec / stimulus side. slave: the receiver.
interface i2s_if #(
  parameter int DATA_WIDTH = 16
);
  import i2s_pkg::*;

  logic                          bclk;
  logic                          lrclk;
  logic                          sdata;
  logic signed [DATA_WIDTH-1:0]  leftOut;
  logic signed [DATA_WIDTH-1:0]  rightOut;
  logic                          sampleValid;
  logic                          frameError;

  modport master (
    output bclk, lrclk, sdata,
    input  leftOut, rightOut, sampleValid, frameError
  );

  modport slave (
    input  bclk, lrclk, sdata,
    output leftOut, rightOut, sampleValid, frameError
  );

endinterface

// File: rtl/i2s_sync.sv
// i2s_sync: SYNC_STAGES-deep flop chain bringing one asynchronous pin into
// the clk domain. Resets to 0.
//   clk   - system clock
//   reset - asynchronous, active-high
//   d     - asynchronous input
//   q     - synchronized output
module i2s_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: Philips-format I2S receiver (MSB first, one-bit delay after each
// LRCLK edge). Oversamples BCLK/LRCLK/SDATA on clk, captures the first
// DATA_WIDTH bits of each slot and presents a left/right pair with a
// single-cycle strobe once a left word has been followed by a right word.
//   clk   - system clock, at least 8x BCLK
//   reset - asynchronous, active-high
//   bus   - i2s_if.slave: serial pins in, sample pair / strobes out
module i2s_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   reset,
  i2s_if.slave   bus
);
  import i2s_pkg::*;

  localparam int CNT_W = i2s_cnt_w(DATA_WIDTH);

  logic bclk_s;
  logic lrclk_s;
  logic sdata_s;

  i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk   (clk),
    .reset (reset),
    .d     (bus.bclk),
    .q     (bclk_s)
  );

  i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk   (clk),
    .reset (reset),
    .d     (bus.lrclk),
    .q     (lrclk_s)
  );

  i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sdata),
    .q     (sdata_s)
  );

  // Stage p0 -> p1: BCLK rise detection. lrclk/sdata are registered in the
  // same stage so every decision sees the pin values from the rise itself.
  logic bclk_p0;
  logic vld_p1;
  logic lr_p1;
  logic sd_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      lr_p1   <= 1'b0;
    end else begin
      bclk_p0 <= bclk_s;
      vld_p1  <= bclk_s & ~bclk_p0;
      lr_p1   <= lrclk_s;
    end
  end

  always_ff @(posedge clk) begin
    sd_p1 <= sdata_s;
  end

  // Stage p1 -> p2: deframing FSM and word assembly.
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             chan;        // channel of the word in progress, 1 = right
  logic             lr_prev;     // lrclk seen at the previous rise
  logic             left_pend;   // a complete left word awaits its right word

  logic signed [DATA_WIDTH-1:0] sr_p2;
  logic signed [DATA_WIDTH-1:0] lhold_p2;

  logic lr_edge;
  logic shift_en;
  logic hold_en;

  // An LRCLK change is only recognised at a BCLK rise; that rise is the
  // delay bit, so it never shifts data.
  assign lr_edge  = vld_p1 && (lr_p1 != lr_prev);
  assign shift_en = (state == SHIFT) && vld_p1 && !lr_edge;
  assign hold_en  = (state == DONE) && !chan;

  always_ff @(posedge clk) begin
    if (shift_en) begin
      sr_p2 <= {sr_p2[DATA_WIDTH-2:0], sd_p1};
    end
    if (hold_en) begin
      lhold_p2 <= sr_p2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      chan            <= 1'b0;
      lr_prev         <= 1'b0;
      left_pend       <= 1'b0;
      bus.leftOut     <= '0;
      bus.rightOut    <= '0;
      bus.sampleValid <= 1'b0;
      bus.frameError  <= 1'b0;
    end else begin
      bus.sampleValid <= 1'b0;
      bus.frameError  <= 1'b0;

      if (vld_p1) begin
        lr_prev <= lr_p1;
      end

      case (state)
        IDLE, WAIT: begin
          if (lr_edge) begin
            state <= SHIFT;
            chan  <= lr_p1;
            cnt   <= '0;
          end
        end

        SHIFT: begin
          if (lr_edge) begin
            // Word cut short: drop it and restart on the new channel, this
            // edge being the new word's delay bit. A dropped left word must
            // not pair with the next right word.
            bus.frameError <= 1'b1;
            if (!chan) begin
              left_pend <= 1'b0;
            end
            chan <= lr_p1;
            cnt  <= '0;
          end else if (vld_p1) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (!chan) begin
            left_pend <= 1'b1;
          end else if (left_pend) begin
            bus.leftOut     <= lhold_p2;
            bus.rightOut    <= sr_p2;
            bus.sampleValid <= 1'b1;
            left_pend       <= 1'b0;
          end
          state <= WAIT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: bench for i2s_rx. Drives pin-level I2S at BCLK = clk/8, logs
// every BCLK rise (lrclk, sdata) and predicts strobes / frame errors from
// the word-segment rules of I2S framing.
module tb_i2s_rx;

  localparam int DW = 16;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  i2s_if #(.DATA_WIDTH(DW)) bus ();

  i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Pin-level stream since the last reset release, one entry per BCLK rise.
  bit s_lr[$];
  bit s_sd[$];
  int rise_cyc;
  int bit16_cyc;

  // Observed DUT behaviour.
  logic [15:0] got_l[$];
  logic [15:0] got_r[$];
  int          got_c[$];
  int          got_err = 0;
  int          stab_bad = 0;
  logic [15:0] prev_l = '0;
  logic [15:0] prev_r = '0;

  // Model predictions.
  logic [15:0] m_l[$];
  logic [15:0] m_r[$];
  int          m_err;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          wlen;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t tbl[6];

  always @(negedge clk) begin
    if (bus.sampleValid) begin
      got_l.push_back(bus.leftOut);
      got_r.push_back(bus.rightOut);
      got_c.push_back(cyc);
    end
    if (bus.frameError) got_err++;
    if (!reset && !bus.sampleValid &&
        (bus.leftOut != prev_l || bus.rightOut != prev_r)) stab_bad++;
    prev_l = bus.leftOut;
    prev_r = bus.rightOut;
  end

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chkn(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic send_bit(input bit lr, input bit sd);
    @(negedge clk);
    bus.bclk  = 1'b0;
    bus.lrclk = lr;
    bus.sdata = sd;
    repeat (4) @(negedge clk);
    bus.bclk = 1'b1;
    rise_cyc = cyc;
    s_lr.push_back(lr);
    s_sd.push_back(sd);
    repeat (3) @(negedge clk);
  endtask

  // Slot position 0 is the delay bit; the word follows MSB first.
  task automatic send_slot(input bit lr, input logic [31:0] word, input int wlen, input int slen);
    bit sd;
    for (int i = 0; i < slen; i++) begin
      sd = 1'b0;
      if (i >= 1 && i <= wlen) sd = word[wlen - i];
      send_bit(lr, sd);
      if (i == DW) bit16_cyc = rise_cyc;
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int wlen);
    send_slot(1'b0, l, wlen, 32);
    send_slot(1'b1, r, wlen, 32);
  endtask

  task automatic clear_obs();
    s_lr.delete();
    s_sd.delete();
    got_l.delete();
    got_r.delete();
    got_c.delete();
    got_err = 0;
  endtask

  // Split the rise stream into segments at lrclk changes. Each segment's
  // first rise is the delay bit; a segment with DW or more bits after it is
  // a complete word, a shorter one ended by another change is an error.
  task automatic run_model();
    int          starts[$];
    int          n;
    int          en;
    int          nb;
    bit          ch;
    bit          pend;
    logic [15:0] w;
    logic [15:0] pl;
    m_l.delete();
    m_r.delete();
    m_err = 0;
    pend  = 1'b0;
    pl    = '0;
    n = s_lr.size();
    for (int i = 0; i < n; i++)
      if (s_lr[i] != ((i == 0) ? 1'b0 : s_lr[i-1])) starts.push_back(i);
    for (int k = 0; k < starts.size(); k++) begin
      en = (k + 1 < starts.size()) ? starts[k+1] : n;
      nb = en - starts[k] - 1;
      ch = s_lr[starts[k]];
      if (nb >= DW) begin
        w = '0;
        for (int j = 1; j <= DW; j++) w = {w[14:0], s_sd[starts[k] + j]};
        if (!ch) begin
          pl   = w;
          pend = 1'b1;
        end else if (pend) begin
          m_l.push_back(pl);
          m_r.push_back(w);
          pend = 1'b0;
        end
      end else if (k + 1 < starts.size()) begin
        m_err++;
        if (!ch) pend = 1'b0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    run_model();
    chkn({tag, " strobe count"}, got_l.size(), m_l.size());
    chkn({tag, " frameError count"}, got_err, m_err);
    for (int i = 0; i < got_l.size() && i < m_l.size(); i++) begin
      chk16({tag, " left"}, got_l[i], m_l[i]);
      chk16({tag, " right"}, got_r[i], m_r[i]);
    end
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL timeout: simulation did not finish, fails=%0d", fails);
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    int e0;

    tbl[0] = '{32'h7FFF, 32'h8000, 16, 16'h7FFF, 16'h8000};
    tbl[1] = '{32'h0001, 32'hFFFF, 16, 16'h0001, 16'hFFFF};
    tbl[2] = '{32'h1234, 32'hEDCC, 16, 16'h1234, 16'hEDCC};
    tbl[3] = '{32'h8001, 32'h7FFE, 16, 16'h8001, 16'h7FFE};
    tbl[4] = '{32'h0000, 32'h0000, 16, 16'h0000, 16'h0000};
    tbl[5] = '{32'hABCDEF, 32'h123456, 24, 16'hABCD, 16'h1234};

    reset     = 1'b1;
    bus.bclk  = 1'b0;
    bus.lrclk = 1'b0;
    bus.sdata = 1'b0;
    repeat (3) @(negedge clk);
    chk16("reset leftOut", bus.leftOut, 16'h0000);
    chk16("reset rightOut", bus.rightOut, 16'h0000);
    chkn("reset sampleValid", int'(bus.sampleValid), 0);
    chkn("reset frameError", int'(bus.frameError), 0);
    reset = 1'b0;
    clear_obs();
    repeat (4) @(negedge clk);

    // A right slot first so the first left slot starts on an LRCLK edge.
    send_slot(1'b1, 32'h0, 16, 17);

    for (int i = 0; i < 6; i++) begin
      n0 = got_l.size();
      send_frame(tbl[i].l, tbl[i].r, tbl[i].wlen);
      repeat (10) @(negedge clk);
      chkn($sformatf("vec%0d strobes", i), got_l.size() - n0, 1);
      if (got_l.size() > n0) begin
        chk16($sformatf("vec%0d left", i), got_l[n0], tbl[i].exp_l);
        chk16($sformatf("vec%0d right", i), got_r[n0], tbl[i].exp_r);
        if (i == 0) chkn("strobe latency", got_c[n0] - bit16_cyc, SS + 3);
      end
    end
    chkn("table frameErrors", got_err, 0);
    check_model("table");

    // Short left word: 10 bits, then a full right slot.
    n0 = got_l.size();
    e0 = got_err;
    send_slot(1'b0, 32'h5555, 16, 11);
    send_slot(1'b1, 32'h1111, 16, 32);
    repeat (10) @(negedge clk);
    chkn("short word frameError", got_err - e0, 1);
    chkn("short word no strobe", got_l.size() - n0, 0);
    send_frame(32'h2468, 32'hECA8, 16);
    repeat (10) @(negedge clk);
    chkn("after short strobes", got_l.size() - n0, 1);
    if (got_l.size() > n0) begin
      chk16("after short left", got_l[n0], 16'h2468);
      chk16("after short right", got_r[n0], 16'hECA8);
    end
    check_model("short");

    // Startup alignment: reset released in the middle of a right slot.
    send_slot(1'b0, 32'h4444, 16, 32);
    send_slot(1'b1, 32'h3333, 16, 12);
    bus.bclk = 1'b0;
    reset    = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    clear_obs();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    repeat (10) @(negedge clk);
    chkn("startup no early strobe", got_l.size(), 0);
    send_frame(32'h0F0F, 32'hF0F0, 16);
    repeat (10) @(negedge clk);
    chkn("startup strobes", got_l.size(), 1);
    if (got_l.size() > 0) begin
      chk16("startup left", got_l[0], 16'h0F0F);
      chk16("startup right", got_r[0], 16'hF0F0);
    end
    check_model("startup");

    // Reset during right-channel bit 8.
    send_frame(32'h1357, 32'h9BDF, 16);
    send_slot(1'b0, 32'h6666, 16, 32);
    send_slot(1'b1, 32'h7777, 16, 9);
    check_model("pre-reset");
    #2 reset = 1'b1;
    #1;
    chk16("async reset leftOut", bus.leftOut, 16'h0000);
    chk16("async reset rightOut", bus.rightOut, 16'h0000);
    chkn("async reset sampleValid", int'(bus.sampleValid), 0);
    bus.bclk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    clear_obs();
    repeat (20) @(negedge clk);
    chkn("no stale strobe", got_l.size(), 0);
    send_frame(32'hAAAA, 32'h5555, 16);
    send_frame(32'hC3C3, 32'h3C3C, 16);
    repeat (10) @(negedge clk);
    chkn("post-reset strobes", got_l.size(), 1);
    if (got_l.size() > 0) begin
      chk16("post-reset left", got_l[0], 16'hC3C3);
      chk16("post-reset right", got_r[0], 16'h3C3C);
    end
    check_model("post-reset");

    // Randomized slots, occasionally too short to hold a word.
    for (int f = 0; f < 24; f++) begin
      for (int c = 0; c < 2; c++) begin
        int slen;
        if ($urandom_range(0, 5) == 0) slen = $urandom_range(2, 16);
        else                           slen = $urandom_range(17, 32);
        send_slot(1'(c), 32'($urandom_range(0, 65535)), 16, slen);
      end
    end
    repeat (10) @(negedge clk);
    check_model("random");

    chkn("output stability", stab_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
